// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/response bundle between the MEM stage and dm_responder
interface dm_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_byteen;
    logic [2:0]  req_ldop;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_byteen, req_ldop,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_byteen, req_ldop,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - data-memory responder with one-entry write buffer, load extension and post-reset clear
module dm_responder #(
    parameter int ADDR_W = 12
) (
    input  logic          clk,
    input  logic          reset,
    dm_responder_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_cnt_q;
    logic [31:0]         mem [DEPTH];

    logic                buf_valid_q;
    logic [ADDR_W-1:0]   buf_idx_q;
    logic [31:0]         buf_data_q;
    logic [3:0]          buf_be_q;

    logic                ready;
    logic                accept;
    logic                is_write;
    logic                is_read;
    logic [ADDR_W-1:0]   req_idx;
    logic [31:0]         fetch_word;
    logic [31:0]         merged_word;
    logic [15:0]         half_sel;
    logic [7:0]          byte_sel;
    logic [31:0]         load_data;
    logic                load_err;

    logic                resp_valid_q;
    logic [31:0]         resp_rdata_q;
    logic                resp_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                ready = 1'b1;
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    assign accept   = bus.req_valid && ready;
    assign is_write = accept && (bus.req_byteen != 4'b0000);
    assign is_read  = accept && (bus.req_byteen == 4'b0000);
    assign req_idx  = bus.req_addr[ADDR_W+1:2];

    // A buffered entry is never committed on a reset edge; the clear sweep owns the RAM then.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == ST_CLEAR) begin
                mem[clr_cnt_q] <= '0;
            end else if (buf_valid_q) begin
                for (int i = 0; i < 4; i++) begin
                    if (buf_be_q[i]) begin
                        mem[buf_idx_q][8*i +: 8] <= buf_data_q[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_idx_q   <= '0;
            buf_data_q  <= '0;
            buf_be_q    <= '0;
        end else if (is_write) begin
            buf_valid_q <= 1'b1;
            buf_idx_q   <= req_idx;
            buf_data_q  <= bus.req_wdata;
            buf_be_q    <= bus.req_byteen;
        end else begin
            buf_valid_q <= 1'b0;
        end
    end

    assign fetch_word = mem[req_idx];

    // Forward the not-yet-committed buffered lanes so write-then-read sees new data.
    always_comb begin
        merged_word = fetch_word;
        for (int i = 0; i < 4; i++) begin
            if (buf_valid_q && (buf_idx_q == req_idx) && buf_be_q[i]) begin
                merged_word[8*i +: 8] = buf_data_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        load_data = '0;
        load_err  = 1'b0;
        half_sel  = bus.req_addr[1] ? merged_word[31:16] : merged_word[15:0];
        byte_sel  = merged_word[{bus.req_addr[1:0], 3'b000} +: 8];
        case (bus.req_ldop)
            3'd1: begin
                if (bus.req_addr[0]) load_err = 1'b1;
                else                 load_data = {{16{half_sel[15]}}, half_sel};
            end
            3'd2: begin
                if (bus.req_addr[0]) load_err = 1'b1;
                else                 load_data = {16'h0000, half_sel};
            end
            3'd3:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_data = {24'h000000, byte_sel};
            default: begin
                if (bus.req_addr[1:0] != 2'b00) load_err = 1'b1;
                else                            load_data = merged_word;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            resp_valid_q <= is_read;
            if (is_read) begin
                resp_rdata_q <= load_data;
                resp_err_q   <= load_err;
            end
        end
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - directed and randomized checks of dm_responder against a word-array model
module tb_dm_responder;
    localparam int AW    = 4;
    localparam int DEPTH = 1 << AW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dm_responder_if bus();

    dm_responder #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic void model_load(input logic [31:0] a, input logic [2:0] op,
                                       output logic [31:0] d, output logic e);
        logic [31:0] w;
        logic [15:0] h;
        logic [7:0]  b;
        w = model_mem[a[AW+1:2]];
        h = 16'(w >> (32'(a[1]) * 16));
        b = 8'(w >> (32'(a[1:0]) * 8));
        d = 32'h0;
        e = 1'b0;
        case (op)
            3'd1:    if (a[0]) e = 1'b1; else d = 32'($signed(h));
            3'd2:    if (a[0]) e = 1'b1; else d = 32'(h);
            3'd3:    d = 32'($signed(b));
            3'd4:    d = 32'(b);
            default: if (a[1:0] != 2'b00) e = 1'b1; else d = w;
        endcase
    endfunction

    function automatic void model_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) model_mem[a[AW+1:2]][8*i +: 8] = wd[8*i +: 8];
        end
    endfunction

    // Called just after a negedge; returns just after the following negedge.
    task automatic step(input logic v, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [2:0] op, input string tag);
        logic rd;
        bus.req_valid  = v;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.req_byteen = be;
        bus.req_ldop   = op;
        if (v) chk({tag, ":ready"}, 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        rd = v && (be == 4'b0000);
        if (v && be != 4'b0000) model_store(a, wd, be);
        if (rd) model_load(a, op, exp_rdata, exp_err);
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk({tag, ":valid"}, 32'(bus.resp_valid), 32'(rd));
        chk({tag, ":rdata"}, bus.resp_rdata, exp_rdata);
        chk({tag, ":err"}, 32'(bus.resp_err), 32'(exp_err));
    endtask

    task automatic do_reset(input string tag);
        int lo;
        bus.req_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk({tag, ":rst_ready"}, 32'(bus.req_ready), 32'd0);
        chk({tag, ":rst_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, ":rst_rdata"}, bus.resp_rdata, 32'd0);
        chk({tag, ":rst_err"}, 32'(bus.resp_err), 32'd0);
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;
        exp_rdata = 32'h0;
        exp_err   = 1'b0;
        reset = 1'b0;
        lo = 1;
        while (!bus.req_ready && lo < 200) begin
            @(negedge clk);
            if (!bus.req_ready) lo++;
        end
        chk({tag, ":clear_cycles"}, 32'(lo), 32'(DEPTH));
    endtask

    logic [31:0] first_data;
    logic        v_r;
    logic [3:0]  be_r;

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_byteen = '0;
        bus.req_ldop   = '0;
        @(negedge clk);
        do_reset("init");

        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 32'(i * 4), 32'hA5000000 | 32'(i * 32'h01010101 + 1), 4'hF, 3'd0, "preload");
        step(1'b0, 0, 0, 0, 0, "idle");
        do_reset("clr");
        for (int i = 0; i < DEPTH; i++) step(1'b1, 32'(i * 4), 0, 4'h0, 3'd0, "clr_read");
        step(1'b1, 32'h3C, 0, 4'h0, 3'd0, "lw3c");
        chk("lw3c_const", bus.resp_rdata, 32'h00000000);

        step(1'b1, 32'h10, 32'h8899AABB, 4'hF, 3'd0, "sw10");
        step(1'b1, 32'h12, 32'h00F00000, 4'b0100, 3'd0, "sb12");
        step(1'b1, 32'h10, 0, 4'h0, 3'd0, "lw10");
        chk("lw10_const", bus.resp_rdata, 32'h88F0AABB);
        step(1'b1, 32'h12, 0, 4'h0, 3'd3, "lb12");
        chk("lb12_const", bus.resp_rdata, 32'hFFFFFFF0);
        step(1'b1, 32'h12, 0, 4'h0, 3'd4, "lbu12");
        chk("lbu12_const", bus.resp_rdata, 32'h000000F0);
        step(1'b1, 32'h12, 0, 4'h0, 3'd1, "lh12");
        chk("lh12_const", bus.resp_rdata, 32'hFFFF88F0);
        step(1'b1, 32'h10, 0, 4'h0, 3'd2, "lhu10");
        chk("lhu10_const", bus.resp_rdata, 32'h0000AABB);

        step(1'b1, 32'h20, 32'hCAFEBABE, 4'hF, 3'd0, "sw20");
        step(1'b0, 0, 0, 0, 0, "idle");
        step(1'b1, 32'h20, 32'h00001234, 4'b0011, 3'd0, "sh20");
        step(1'b1, 32'h20, 0, 4'h0, 3'd0, "fwd20");
        chk("fwd20_const", bus.resp_rdata, 32'hCAFE1234);

        step(1'b1, 32'h21, 0, 4'h0, 3'd0, "lw21");
        chk("lw21_err", 32'(bus.resp_err), 32'd1);
        step(1'b1, 32'h23, 0, 4'h0, 3'd1, "lh23");
        step(1'b1, 32'h23, 0, 4'h0, 3'd3, "lb23");
        step(1'b0, 0, 0, 0, 0, "hold");

        step(1'b1, 32'h00, 0, 4'h0, 3'd0, "wrap00");
        first_data = bus.resp_rdata;
        step(1'b1, 32'h04, 0, 4'h0, 3'd0, "wrap04");
        step(1'b1, 32'h40, 0, 4'h0, 3'd0, "wrap40");
        chk("wrap_alias", bus.resp_rdata, first_data);

        step(1'b1, 32'h08, 32'h11111111, 4'hF, 3'd0, "sw08");
        do_reset("midwr");
        step(1'b1, 32'h08, 0, 4'h0, 3'd0, "lw08");
        chk("lw08_const", bus.resp_rdata, 32'h00000000);

        for (int n = 0; n < 400; n++) begin
            if (n == 200) begin
                step(1'b1, $urandom, $urandom, 4'hF, 3'd0, "rnd_prewr");
                do_reset("rnd");
            end
            v_r  = ($urandom_range(0, 4) != 0);
            be_r = ($urandom_range(0, 1) != 0) ? 4'(($urandom_range(1, 15))) : 4'h0;
            step(v_r, $urandom, $urandom, be_r, 3'($urandom_range(0, 7)), "rnd");
        end
        step(1'b0, 0, 0, 0, 0, "tail");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dm_responder.md
# dm_responder

Data-memory responder: the memory end of the CPU's store/load data interface. It accepts lane-aligned write requests (address, shifted write data, 4-bit byte enables) and read requests carrying a load-extension op, holds each write in a one-entry write buffer, and returns sign/zero-extended load data one cycle after acceptance. After every reset it zero-clears its RAM with a sweep counter. It sits between the MEM pipeline stage and the data RAM.

## Interface

- ADDR_W, 12, word-address width; RAM depth = 2^ADDR_W words.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present this cycle.
- req_ready  output  1  responder can accept; a request is accepted on an edge where req_valid && req_ready.
- req_addr  input  32  byte address; word index = req_addr[ADDR_W+1:2]; bits above are ignored, so addresses wrap.
- req_wdata  input  32  write data, already shifted to the byte lanes.
- req_byteen  input  4  byte enables; nonzero = write, 4'b0000 = read.
- req_ldop  input  3  read extension: 0 LW, 1 LH, 2 LHU, 3 LB, 4 LBU; 5-7 are treated as LW; ignored on writes.
- resp_valid  output  1  one-cycle pulse, read result valid.
- resp_rdata  output  32  extended load data.
- resp_err  output  1  misaligned read, qualified by resp_valid.

## Operation

- States: CLEAR, IDLE.
  - After reset: CLEAR, sweep counter = 0.
  - CLEAR writes 0 to RAM[counter] each cycle and increments the counter.
  - After the write to word 2^ADDR_W-1, the state goes to IDLE.
  - req_ready = (state == IDLE).
- Write accepted:
  - Load the write buffer: valid=1, index, data, byteen.
  - On the next edge, enabled lanes are committed to RAM[index]. Disabled lanes are untouched.
  - If no new write is accepted on that edge, the buffer valid bit clears.
  - Writes produce no response.
- Back-to-back writes:
  - A write accepted while the buffer holds an entry commits the old entry and loads the new one on the same edge.
  - There is never a stall.
- Read accepted:
  - Fetch word = RAM[index] (pre-edge contents).
  - For each lane i with buffer valid, buffer index equal to the read index, and buffer byteen[i] set, lane i is replaced by the buffer data lane i.
  - Extension uses addr[1:0]:
    - LW: the whole word.
    - LH/LHU: halfword at bits [16*addr[1]+:16], sign- or zero-extended.
    - LB/LBU: byte at bits [8*addr[1:0]+:8], sign- or zero-extended.
- Misalignment:
  - LW with addr[1:0] != 0, or LH/LHU with addr[0] != 0, gives resp_err=1 and resp_rdata=0.
  - Otherwise resp_err=0.
- A write with a misaligned or irregular byteen pattern is honoured lane-by-lane. No error is raised.
- Requests arriving while in CLEAR are not accepted. The requester must hold them.

## Timing

- Reset values on the edge where reset=1:
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0.
  - Write buffer invalidated; state=CLEAR; counter=0.
- Clear duration: exactly 2^ADDR_W cycles after reset deasserts. req_ready rises in the following cycle.
- Read latency: a read accepted at edge N gives resp_valid=1 with data during cycle N..N+1 (registered). resp_valid deasserts at edge N+1 unless another read is accepted at edge N+1.
- Full throughput: one request per cycle in IDLE.
- Write-then-read to the same word on consecutive edges returns the merged new data (forwarding).
- Reset mid-operation:
  - Any buffered write is discarded, not committed.
  - A pending response is dropped.
  - The clear restarts from word 0.
- resp_rdata and resp_err hold their last value while resp_valid=0. They are zeroed only by reset.

## Test plan

- Reset clear (ADDR_W=4), with RAM preloaded nonzero:
  - Pulse reset → req_ready=0 for 16 cycles, then 1.
  - LW at 0x3C → resp_rdata=0x00000000, resp_err=0.
- Byte-enable write plus extension:
  - SW 0x8899AABB to 0x10, then write byteen=4'b0100 wdata=0x00F00000 to 0x12.
  - LW 0x10 → 0x88F0AABB.
  - LB 0x12 → 0xFFFFFFF0.
  - LBU 0x12 → 0x000000F0.
  - LH 0x12 → 0xFFFF88F0.
  - LHU 0x10 → 0x0000AABB.
- Forwarding:
  - Write byteen=4'b0011 wdata=0x00001234 to 0x20, then LW 0x20 on the very next edge (old word 0xCAFEBABE).
  - → resp_rdata=0xCAFE1234 one cycle later.
- Misalignment:
  - LW 0x21 → resp_err=1, resp_rdata=0.
  - LH 0x23 → resp_err=1.
  - LB 0x23 → resp_err=0.
- Throughput plus wrap:
  - Reads to 0x00, 0x04, and 0x40 (wraps to word 0 at ADDR_W=4) on consecutive edges → three consecutive resp_valid cycles.
  - Data for 0x00 equals data for 0x40.
- Reset mid-write:
  - Accept SW 0x11111111 to 0x08 and assert reset on the next edge.
  - After the clear, LW 0x08 → 0x00000000.
